// File: rtl/repacketizer_pkg.sv
// Shared types and constants for the framed repacketizer.
package repacketizer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    PAD     = 2'd3
  } state_t;

  localparam int DEFAULT_FRAME_WORDS = 16;
  localparam int DEFAULT_PAD_VALUE   = 0;

  // One width covers both the frame position (0..FRAME_WORDS-1) and the idle count (0..FLUSH_TIMEOUT).
  function automatic int cnt_width(input int frame_words, input int flush_timeout);
    int span;
    span = (frame_words > flush_timeout + 1) ? frame_words : flush_timeout + 1;
    return (span <= 2) ? 1 : $clog2(span);
  endfunction

endpackage

// File: rtl/repacketizer_framed_output_skid_reg.sv
// One-entry output register with ready/valid and frame start/end sideband.
module output_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_first,
  input  logic         load_last,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         first,
  output logic         last,
  output logic         free
);

  assign free = !valid || ready;

  // Register refills only when empty or when the current word is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
      first <= 1'b0;
      last  <= 1'b0;
    end else if (free) begin
      if (load) begin
        data  <= load_data;
        valid <= 1'b1;
        first <= load_first;
        last  <= load_last;
      end else begin
        valid <= 1'b0;
        first <= 1'b0;
        last  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/repacketizer_framed.sv
// Packs a size+data packet stream into fixed-length frames with idle-timeout padding.
// Optional macro REPACKETIZER_SEQ_HEADER_EN puts an 8-bit frame sequence number in word 0 of each frame.
module repacketizer_framed
  import repacketizer_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    SIZE_WIDTH    = 8,
  parameter int                    FRAME_WORDS   = DEFAULT_FRAME_WORDS,
  parameter int                    FLUSH_TIMEOUT = 32,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE     = DATA_WIDTH'(DEFAULT_PAD_VALUE)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [SIZE_WIDTH-1:0] sizeData,
  input  logic                  sizeValid,
  output logic                  sizeReady,
  input  logic [DATA_WIDTH-1:0] dataData,
  input  logic                  dataValid,
  output logic                  dataReady,
  output logic [DATA_WIDTH-1:0] packetout,
  output logic                  packetoutValid,
  input  logic                  packetoutReady,
  output logic                  packetoutStart,
  output logic                  packetoutEnd
);

  localparam int            CW        = cnt_width(FRAME_WORDS, FLUSH_TIMEOUT);
  localparam logic [CW-1:0] LAST_WORD = CW'(FRAME_WORDS - 1);
  localparam logic [CW-1:0] TIMEOUT   = CW'(FLUSH_TIMEOUT);

  state_t                  state;
  state_t                  next_state;
  logic [CW-1:0]           word_cnt;
  logic [CW-1:0]           idle_cnt;
  logic [SIZE_WIDTH-1:0]   rem_cnt;
  logic                    load;
  logic [DATA_WIDTH-1:0]   load_data;
  logic                    size_take;
  logic                    data_take;
  logic                    size_hs;
  logic                    data_hs;
  logic                    free;
  logic                    seq_slot;
  logic [DATA_WIDTH-1:0]   seq_word;

  assign size_hs   = sizeValid & size_take;
  assign data_hs   = dataValid & data_take;
  assign sizeReady = size_take & ~RESET;
  assign dataReady = data_take & ~RESET;

`ifdef REPACKETIZER_SEQ_HEADER_EN
  logic [7:0] seq_num;

  assign seq_slot = (word_cnt == '0);
  assign seq_word = DATA_WIDTH'(seq_num);

  // Frame sequence number advances as each frame's last word is loaded.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      seq_num <= 8'd0;
    end else if (load && (word_cnt == LAST_WORD)) begin
      seq_num <= seq_num + 8'd1;
    end
  end
`else
  assign seq_slot = 1'b0;
  assign seq_word = '0;
`endif

  // Next-state and output-word selection; every word waits for a free output slot.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_data  = '0;
    size_take  = 1'b0;
    data_take  = 1'b0;
    case (state)
      IDLE: begin
        if (idle_cnt == TIMEOUT) begin
          next_state = PAD;
        end else begin
          size_take = free;
          if (sizeValid && free && (sizeData != '0)) begin
            next_state = HEADER;
          end else begin
            next_state = IDLE;
          end
        end
      end
      HEADER: begin
        if (free) begin
          load = 1'b1;
          if (seq_slot) begin
            load_data  = seq_word;
            next_state = HEADER;
          end else begin
            load_data  = DATA_WIDTH'(rem_cnt);
            next_state = PAYLOAD;
          end
        end else begin
          next_state = HEADER;
        end
      end
      PAYLOAD: begin
        if (seq_slot) begin
          load       = free;
          load_data  = seq_word;
          next_state = PAYLOAD;
        end else begin
          data_take = free;
          if (dataValid && free) begin
            load      = 1'b1;
            load_data = dataData;
            if (rem_cnt == SIZE_WIDTH'(1)) begin
              next_state = IDLE;
            end else begin
              next_state = PAYLOAD;
            end
          end else begin
            next_state = PAYLOAD;
          end
        end
      end
      PAD: begin
        if (free) begin
          load      = 1'b1;
          load_data = PAD_VALUE;
          if (word_cnt == LAST_WORD) begin
            next_state = IDLE;
          end else begin
            next_state = PAD;
          end
        end else begin
          next_state = PAD;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State and counters; the idle counter only runs inside a partially filled frame.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      word_cnt <= '0;
      idle_cnt <= '0;
      rem_cnt  <= '0;
    end else begin
      state <= next_state;
      if (load) begin
        word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + CW'(1);
      end
      if (size_hs && (sizeData != '0)) begin
        rem_cnt <= sizeData;
      end else if (data_hs) begin
        rem_cnt <= rem_cnt - SIZE_WIDTH'(1);
      end
      if ((state != IDLE) || (next_state != IDLE) || size_hs) begin
        idle_cnt <= '0;
      end else if (word_cnt != '0) begin
        idle_cnt <= idle_cnt + CW'(1);
      end
    end
  end

  output_skid_reg #(
    .W(DATA_WIDTH)
  ) u_out (
    .clk        (CLK),
    .rst        (RESET),
    .load       (load),
    .load_data  (load_data),
    .load_first (word_cnt == '0),
    .load_last  (word_cnt == LAST_WORD),
    .ready      (packetoutReady),
    .data       (packetout),
    .valid      (packetoutValid),
    .first      (packetoutStart),
    .last       (packetoutEnd),
    .free       (free)
  );

endmodule

// File: tb/tb_repacketizer_framed.sv
// Self-checking bench for repacketizer_framed (FRAME_WORDS=8, FLUSH_TIMEOUT=4).
module tb_repacketizer_framed;

  localparam int         FW   = 8;
  localparam int         FT   = 4;
  localparam logic [7:0] PADV = 8'hE5;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] sizeData;
  logic       sizeValid;
  logic       sizeReady;
  logic [7:0] dataData;
  logic       dataValid;
  logic       dataReady;
  logic [7:0] packetout;
  logic       packetoutValid;
  logic       packetoutReady;
  logic       packetoutStart;
  logic       packetoutEnd;

  always #5 CLK = ~CLK;

  repacketizer_framed #(
    .DATA_WIDTH(8), .SIZE_WIDTH(8), .FRAME_WORDS(FW), .FLUSH_TIMEOUT(FT), .PAD_VALUE(PADV)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .sizeData(sizeData), .sizeValid(sizeValid), .sizeReady(sizeReady),
    .dataData(dataData), .dataValid(dataValid), .dataReady(dataReady),
    .packetout(packetout), .packetoutValid(packetoutValid), .packetoutReady(packetoutReady),
    .packetoutStart(packetoutStart), .packetoutEnd(packetoutEnd)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       first;
    logic       last;
  } word_t;

  typedef struct {
    int         scen;
    logic [7:0] data;
  } vec_t;

  word_t      got[$];
  word_t      exp_q[$];
  logic [7:0] size_q[$];
  logic [7:0] data_q[$];
  vec_t       vecs[$];

  int checks = 0;
  int passes = 0;
  int stall_left = 0;
  int low_run = 0;
  bit rand_ready = 1'b0;
  bit rand_dvalid = 1'b0;

  // Reference model state: position within the frame and next sequence number.
  int         m_pos = 0;
  logic [7:0] m_seq = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  task automatic m_word(input logic [7:0] w);
`ifdef REPACKETIZER_SEQ_HEADER_EN
    if (m_pos == 0) begin
      exp_q.push_back('{m_seq, 1'b1, 1'b0});
      m_pos = 1;
    end
`endif
    exp_q.push_back('{w, (m_pos == 0), (m_pos == FW - 1)});
    if (m_pos == FW - 1) begin
      m_pos = 0;
      m_seq = m_seq + 8'd1;
    end else begin
      m_pos++;
    end
  endtask

  task automatic m_packet(input logic [7:0] sz, input logic [7:0] base, input bit rnd);
    size_q.push_back(sz);
    if (sz != 8'd0) begin
      m_word(sz);
      for (int i = 0; i < int'(sz); i++) begin
        logic [7:0] d;
        d = rnd ? 8'($urandom) : base + 8'(i);
        data_q.push_back(d);
        m_word(d);
      end
    end
  endtask

  task automatic m_flush();
    while (m_pos != 0) m_word(PADV);
  endtask

  // One clock: drive just after the rising edge, observe handshakes on the falling edge.
  task automatic step();
    @(posedge CLK);
    #1;
    sizeValid = (size_q.size() != 0);
    sizeData  = sizeValid ? size_q[0] : 8'h00;
    dataValid = (data_q.size() != 0) && (!rand_dvalid || ($urandom_range(0, 3) != 0));
    dataData  = (data_q.size() != 0) ? data_q[0] : 8'h00;
    if (stall_left > 0) begin
      packetoutReady = 1'b0;
      stall_left--;
    end else if (rand_ready && (low_run < 2) && ($urandom_range(0, 3) == 0)) begin
      packetoutReady = 1'b0;
      low_run++;
    end else begin
      packetoutReady = 1'b1;
      low_run = 0;
    end
    @(negedge CLK);
    if (sizeValid && sizeReady) void'(size_q.pop_front());
    if (dataValid && dataReady) void'(data_q.pop_front());
    if (packetoutValid && packetoutReady) got.push_back('{packetout, packetoutStart, packetoutEnd});
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((got.size() < exp_q.size()) && (n < budget)) begin
      step();
      n++;
    end
    for (int i = 0; i < 12; i++) step();
    check({name, " count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; (i < exp_q.size()) && (i < got.size()); i++)
      check({name, " word"}, 32'(got[i]), 32'(exp_q[i]));
  endtask

  task automatic clear_run();
    got.delete();
    exp_q.delete();
  endtask

  function automatic void add_vec(input int s, input logic [7:0] d);
    vecs.push_back('{s, d});
  endfunction

  initial begin
    // Directed frame contents for the exact-fit, split-packet and zero-size cases.
    add_vec(1, 8'h03); add_vec(1, 8'h11); add_vec(1, 8'h12); add_vec(1, 8'h13);
    add_vec(1, 8'h03); add_vec(1, 8'h21); add_vec(1, 8'h22); add_vec(1, 8'h23);
    add_vec(2, 8'h0A);
    for (int i = 1; i <= 10; i++) add_vec(2, 8'(i));
    for (int i = 0; i < 5; i++) add_vec(2, PADV);
    add_vec(3, 8'h02); add_vec(3, 8'hAA); add_vec(3, 8'hBB);
    for (int i = 0; i < 5; i++) add_vec(3, PADV);

    RESET = 1'b1;
    sizeData = 8'h00; sizeValid = 1'b0;
    dataData = 8'h00; dataValid = 1'b0;
    packetoutReady = 1'b1;
    #12;
    check("reset valid", 32'(packetoutValid), 32'd0);
    check("reset data", 32'(packetout), 32'd0);
    check("reset start/end", 32'({packetoutStart, packetoutEnd}), 32'd0);
    check("reset sizeReady", 32'(sizeReady), 32'd0);
    check("reset dataReady", 32'(dataReady), 32'd0);
    @(posedge CLK);
    #1 RESET = 1'b0;

`ifdef REPACKETIZER_SEQ_HEADER_EN
    clear_run();
    for (int f = 0; f < 257; f++) m_packet(8'd6, 8'h00, 1'b1);
    drain("seq frames", 6000);
    check("seq frame0", 32'(got[0].data), 32'h00);
    check("seq frame1", 32'(got[8].data), 32'h01);
    check("seq wrap", 32'(got[2048].data), 32'h00);
`else
    for (int s = 1; s <= 3; s++) begin
      int k;
      clear_run();
      case (s)
        1: begin
          size_q.push_back(8'd3); size_q.push_back(8'd3);
          for (int i = 0; i < 3; i++) data_q.push_back(8'h11 + 8'(i));
          for (int i = 0; i < 3; i++) data_q.push_back(8'h21 + 8'(i));
        end
        2: begin
          size_q.push_back(8'd10);
          for (int i = 1; i <= 10; i++) data_q.push_back(8'(i));
        end
        default: begin
          size_q.push_back(8'd0); size_q.push_back(8'd2);
          data_q.push_back(8'hAA); data_q.push_back(8'hBB);
        end
      endcase
      k = 0;
      for (int i = 0; i < vecs.size(); i++) begin
        if (vecs[i].scen == s) begin
          exp_q.push_back('{vecs[i].data, ((k % FW) == 0), ((k % FW) == FW - 1)});
          k++;
        end
      end
      drain($sformatf("directed%0d", s), 400);
    end
`endif

    // Backpressure mid-payload: the held word must stay put and no data may be taken.
    begin
      int n;
      int dq0;
      clear_run();
      m_packet(8'd7, 8'h40, 1'b0);
      m_flush();
      n = 0;
      while ((got.size() < 3) && (n < 100)) begin
        step();
        n++;
      end
      check("bp reached payload", 32'(got.size()), 32'd3);
      dq0 = data_q.size();
      stall_left = 5;
      for (int i = 0; i < 5; i++) begin
        step();
        check("bp hold valid", 32'(packetoutValid), 32'd1);
        check("bp hold word", 32'({packetout, packetoutStart, packetoutEnd}), 32'(exp_q[3]));
        check("bp dataReady", 32'(dataReady), 32'd0);
        check("bp no consume", 32'(data_q.size()), 32'(dq0));
      end
      drain("backpressure", 400);
    end

    // Asynchronous reset in the middle of a frame discards it.
    begin
      int n;
      clear_run();
      m_packet(8'd6, 8'h60, 1'b0);
      n = 0;
      while ((got.size() < 4) && (n < 100)) begin
        step();
        n++;
      end
      check("rst reached word3", 32'(got.size()), 32'd4);
      RESET = 1'b1;
      #1;
      check("rst mid valid", 32'(packetoutValid), 32'd0);
      check("rst mid data", 32'(packetout), 32'd0);
      check("rst mid flags", 32'({packetoutStart, packetoutEnd}), 32'd0);
      check("rst mid readies", 32'({sizeReady, dataReady}), 32'd0);
      @(posedge CLK);
      #1 RESET = 1'b0;
      size_q.delete();
      data_q.delete();
      clear_run();
      m_pos = 0;
      m_seq = 8'd0;
      m_packet(8'd1, 8'h77, 1'b0);
      m_flush();
      drain("after reset", 400);
      check("after reset start", 32'(got[0].first), 32'd1);
    end

    // Randomised bursts with random data stalls and short output stalls.
    rand_ready = 1'b1;
    rand_dvalid = 1'b1;
    for (int seg = 0; seg < 4; seg++) begin
      clear_run();
      for (int p = 0; p < 6; p++) m_packet(8'($urandom_range(0, 12)), 8'h00, 1'b1);
      m_flush();
      drain($sformatf("random%0d", seg), 3000);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
